// File: rtl/store_buffer_if.sv
// Write channel between the store buffer and data memory.
// The buffer presents the oldest pending store; memory accepts it with wready.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          wvalid;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wready;

  modport master (output wvalid, output waddr, output wdata, input wready);
  modport slave  (input wvalid, input waddr, input wdata, output wready);
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and a slow memory write port.
// Stores drain in order; loads are forwarded from the youngest matching entry.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          empty,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  store_buffer_if.master mem
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic          push;
  logic          drain;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  // Handshake outputs depend only on registered state, never on cpu_* inputs.
  assign stall      = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign mem.wvalid = !empty;
  assign mem.waddr  = mem.wvalid ? addr_q[head_q] : '0;
  assign mem.wdata  = mem.wvalid ? data_q[head_q] : '0;
  assign mem_raddr  = cpu_addr;

  assign push  = cpu_we && !stall;
  assign drain = mem.wvalid && mem.wready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        tail_q          <= tail_q + 1'b1;
        valid_q[tail_q] <= 1'b1;
      end
      if (drain) begin
        head_q          <= head_q + 1'b1;
        valid_q[head_q] <= 1'b0;
      end
      if (push && !drain) begin
        count_q <= count_q + 1'b1;
      end else if (drain && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Entry payload needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  // Walk oldest to youngest from head so the last match is the youngest,
  // which keeps priority correct across the pointer wrap.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign cpu_rdata = fwd_hit ? fwd_data : mem_rdata;

endmodule
